// File: rtl/ccff_chain_loader_if.sv
// Word-stream handshake into the configuration chain loader.
// A word transfers on any prog_clk edge where s_valid && s_ready are both high.
interface ccff_chain_loader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words LSB-first onto a column's ccff chain and holds the fabric isolated.
// Optional marker-based chain integrity check is compiled in with `define CCFF_CHECK_EN.
module ccff_chain_loader #(
  parameter int          DATA_W    = 8,
  parameter int          CHAIN_LEN = 32,
  parameter int          CNT_W     = 16,
  parameter logic [7:0]  MARKER    = 8'hA5
) (
  input  logic               prog_clk,
  input  logic               prog_reset,
  input  logic               start,
  ccff_chain_loader_if.slave s_if,
  output logic               ccff_head,
  output logic               ccff_clk_en,
  input  logic               ccff_tail,
  output logic               isol_n,
  output logic               busy,
  output logic               done,
  output logic               check_err,
  output logic [CNT_W-1:0]   bit_count,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MARK   = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam int BC_W = $clog2(DATA_W + 1);

`ifdef CCFF_CHECK_EN
  localparam int MARK_BITS = 8;
  logic [7:0]       mark_q, mark_d;
  logic             check_err_q, check_err_d;
  logic [CNT_W-1:0] chk_idx;
  logic [2:0]       mark_off;
  logic             chk_win;
`else
  localparam int MARK_BITS = 0;
  logic unused_inputs;
  assign unused_inputs = ^{MARKER, ccff_tail};
`endif

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN + MARK_BITS - 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [BC_W-1:0]   buf_cnt_q, buf_cnt_d;
  logic              head_q, head_d;
  logic              clk_en_q, clk_en_d;
  logic              isol_n_q, isol_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;
  logic              s_ready_c;
  logic              last_shift;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_cnt_d   = buf_cnt_q;
    head_d      = head_q;
    clk_en_d    = 1'b0;
    isol_n_d    = isol_n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bit_count_d = bit_count_q;
    s_ready_c   = 1'b0;
    last_shift  = (bit_count_q == LAST_IDX);
`ifdef CCFF_CHECK_EN
    mark_d      = mark_q;
    check_err_d = check_err_q;
    // The tail is judged in the cycle the enable is presented, i.e. before that advance.
    chk_idx     = bit_count_q - CNT_W'(1);
    mark_off    = 3'(chk_idx - CNT_W'(CHAIN_LEN));
    chk_win     = clk_en_q && (chk_idx >= CNT_W'(CHAIN_LEN)) &&
                  (chk_idx < CNT_W'(CHAIN_LEN + 8));
    if (chk_win && (ccff_tail != MARKER[mark_off])) check_err_d = 1'b1;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          isol_n_d    = 1'b0;
          busy_d      = 1'b1;
          bit_count_d = '0;
          buf_cnt_d   = '0;
`ifdef CCFF_CHECK_EN
          check_err_d = 1'b0;
          // First marker bit goes out immediately so the chain starts moving next cycle.
          head_d      = MARKER[0];
          clk_en_d    = 1'b1;
          bit_count_d = CNT_W'(1);
          mark_d      = MARKER >> 1;
          state_d     = ST_MARK;
`else
          state_d     = ST_DATA;
`endif
        end
      end
      ST_MARK: begin
`ifdef CCFF_CHECK_EN
        head_d      = mark_q[0];
        clk_en_d    = 1'b1;
        mark_d      = mark_q >> 1;
        bit_count_d = bit_count_q + CNT_W'(1);
        if (bit_count_q == CNT_W'(MARK_BITS - 1)) state_d = ST_DATA;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DATA: begin
        if (buf_cnt_q == '0) begin
          // Empty buffer: a fresh word's bit 0 bypasses straight to the head.
          s_ready_c = 1'b1;
          if (s_if.s_valid) begin
            head_d      = s_if.s_data[0];
            clk_en_d    = 1'b1;
            bit_count_d = bit_count_q + CNT_W'(1);
            buf_d       = s_if.s_data >> 1;
            buf_cnt_d   = BC_W'(DATA_W - 1);
          end
        end else begin
          s_ready_c   = (buf_cnt_q == BC_W'(1)) && !last_shift;
          head_d      = buf_q[0];
          clk_en_d    = 1'b1;
          bit_count_d = bit_count_q + CNT_W'(1);
          if (s_ready_c && s_if.s_valid) begin
            buf_d     = s_if.s_data;
            buf_cnt_d = BC_W'(DATA_W);
          end else begin
            buf_d     = buf_q >> 1;
            buf_cnt_d = buf_cnt_q - BC_W'(1);
          end
        end
        if (clk_en_d && last_shift) begin
          buf_cnt_d = '0;
          state_d   = ST_FINISH;
        end
      end
      default: begin
        done_d   = 1'b1;
        isol_n_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      buf_cnt_q   <= '0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      isol_n_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bit_count_q <= '0;
`ifdef CCFF_CHECK_EN
      mark_q      <= '0;
      check_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_cnt_q   <= buf_cnt_d;
      head_q      <= head_d;
      clk_en_q    <= clk_en_d;
      isol_n_q    <= isol_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bit_count_q <= bit_count_d;
`ifdef CCFF_CHECK_EN
      mark_q      <= mark_d;
      check_err_q <= check_err_d;
`endif
    end
  end

  assign s_if.s_ready = s_ready_c;
  assign ccff_head    = head_q;
  assign ccff_clk_en  = clk_en_q;
  assign isol_n       = isol_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign bit_count    = bit_count_q;
  assign dbg_state    = state_q;
`ifdef CCFF_CHECK_EN
  assign check_err    = check_err_q;
`else
  assign check_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader (CHAIN_LEN=20, DATA_W=8) against a modelled downstream chain.
// Follows CCFF_CHECK_EN: with it defined the marker prefix and integrity error are expected.
module tb_ccff_chain_loader;
  localparam int DATA_W    = 8;
  localparam int CHAIN_LEN = 20;
  localparam int CNT_W     = 16;
`ifdef CCFF_CHECK_EN
  localparam int MARK_N = 8;
`else
  localparam int MARK_N = 0;
`endif
  localparam int TOTAL = CHAIN_LEN + MARK_N;

  logic             prog_clk   = 1'b0;
  logic             prog_reset = 1'b0;
  logic             start      = 1'b0;
  logic             ccff_head, ccff_clk_en, ccff_tail;
  logic             isol_n, busy, done, check_err;
  logic [CNT_W-1:0] bit_count;
  logic [1:0]       dbg_state;

  ccff_chain_loader_if #(.DATA_W(DATA_W)) s_if ();

  ccff_chain_loader #(
    .DATA_W(DATA_W), .CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W), .MARKER(8'hA5)
  ) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .s_if(s_if),
    .ccff_head(ccff_head), .ccff_clk_en(ccff_clk_en), .ccff_tail(ccff_tail),
    .isol_n(isol_n), .busy(busy), .done(done), .check_err(check_err),
    .bit_count(bit_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 prog_clk = ~prog_clk;

  // downstream chain model, length selectable per load
  logic [31:0] chain_q = '0;
  int          chain_stages = CHAIN_LEN;
  assign ccff_tail = chain_q[chain_stages-1];
  always @(posedge prog_clk) if (ccff_clk_en) chain_q <= {chain_q[30:0], ccff_head};

  // scoreboard state
  int         n_err = 0;
  int         n_chk = 0;
  logic       got_q[$];
  int         en_cyc_q[$];
  logic [0:0] exp_q[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         glitch_cnt = 0;
  int         cyc = 0;
  logic       err_at_done = 1'b0;
  logic       prev_head = 1'b0;

  // monitor, sampled mid-cycle
  always @(negedge prog_clk) begin
    cyc <= cyc + 1;
    if (prog_reset) begin
      if (ccff_clk_en) begin
        got_q.push_back(ccff_head);
        en_cyc_q.push_back(cyc);
      end else if (ccff_head !== prev_head) begin
        glitch_cnt <= glitch_cnt + 1;
      end
      if (done) begin
        done_cnt    <= done_cnt + 1;
        done_cyc    <= cyc;
        err_at_done <= check_err;
      end
    end
    prev_head <= ccff_head;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge prog_clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    int tries = 0;
    s_if.s_data  = w;
    s_if.s_valid = 1'b1;
    #1;
    while (!s_if.s_ready && tries < 300) begin
      @(negedge prog_clk);
      #1;
      tries++;
    end
    n_chk++;
    if (!s_if.s_ready) begin
      n_err++;
      $display("FAIL send_word: s_ready=%0b after %0d cycles, required 1", s_if.s_ready, tries);
    end
    @(negedge prog_clk);
    s_if.s_valid = 1'b0;
  endtask

  task automatic run_load(input int stages, input int gap, input bit restart, input string tag);
    int   mark_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int   data_bits[20] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 1};
    int   base_got, base_done, base_glitch, waited, bubbles;
    logic exp_err;
    chain_stages = stages;
    exp_q.delete();
    for (int i = 0; i < MARK_N; i++) exp_q.push_back(1'(mark_bits[i]));
    for (int i = 0; i < CHAIN_LEN; i++) exp_q.push_back(1'(data_bits[i]));
`ifdef CCFF_CHECK_EN
    exp_err = (stages != CHAIN_LEN);
`else
    exp_err = 1'b0;
`endif
    base_got    = got_q.size();
    base_done   = done_cnt;
    base_glitch = glitch_cnt;

    pulse_start();
    n_chk++;
    if (busy !== 1'b1 || isol_n !== 1'b0 || check_err !== 1'b0 ||
        bit_count !== CNT_W'(MARK_N > 0 ? 1 : 0)) begin
      n_err++;
      $display("FAIL %s start_entry: busy=%0b isol_n=%0b check_err=%0b bit_count=%0d, required 1 0 0 %0d",
               tag, busy, isol_n, check_err, bit_count, (MARK_N > 0 ? 1 : 0));
    end

    send_word(8'h3C);
    if (gap > 0) tick(gap);
    if (restart) pulse_start();
    send_word(8'hF0);
    send_word(8'h5A);

    waited = 0;
    while (done_cnt == base_done && waited < 300) begin
      tick(1);
      waited++;
    end
    tick(3);

    n_chk++;
    if (done_cnt - base_done !== 1) begin
      n_err++;
      $display("FAIL %s done_count: got %0d pulses, required 1", tag, done_cnt - base_done);
    end
    n_chk++;
    if (got_q.size() - base_got !== TOTAL) begin
      n_err++;
      $display("FAIL %s enable_count: got %0d, required %0d", tag, got_q.size() - base_got, TOTAL);
    end
    for (int i = 0; i < TOTAL; i++) begin
      n_chk++;
      if (base_got + i >= got_q.size()) begin
        n_err++;
        $display("FAIL %s head[%0d]: got none, required %0b", tag, i, exp_q[i]);
      end else if (got_q[base_got+i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s head[%0d]: got %0b, required %0b", tag, i, got_q[base_got+i], exp_q[i]);
      end
    end
    if (got_q.size() - base_got == TOTAL) begin
      bubbles = en_cyc_q[en_cyc_q.size()-1] - en_cyc_q[base_got] + 1 - TOTAL;
      n_chk++;
      if ((gap >= 10) ? (bubbles == 0) : (bubbles != 0)) begin
        n_err++;
        $display("FAIL %s stall_cycles: got %0d, required %s", tag, bubbles, (gap >= 10) ? ">0" : "0");
      end
      n_chk++;
      if (done_cyc - en_cyc_q[en_cyc_q.size()-1] !== 1) begin
        n_err++;
        $display("FAIL %s done_latency: got %0d, required 1", tag, done_cyc - en_cyc_q[en_cyc_q.size()-1]);
      end
    end
    n_chk++;
    if (glitch_cnt !== base_glitch) begin
      n_err++;
      $display("FAIL %s head_hold: got %0d changes without enable, required 0", tag, glitch_cnt - base_glitch);
    end
    n_chk++;
    if (isol_n !== 1'b1 || busy !== 1'b0 || bit_count !== CNT_W'(TOTAL)) begin
      n_err++;
      $display("FAIL %s final: isol_n=%0b busy=%0b bit_count=%0d, required 1 0 %0d",
               tag, isol_n, busy, bit_count, TOTAL);
    end
    n_chk++;
    if (err_at_done !== exp_err || check_err !== exp_err) begin
      n_err++;
      $display("FAIL %s check_err: at_done=%0b now=%0b, required %0b", tag, err_at_done, check_err, exp_err);
    end
  endtask

  // scenarios
  task automatic test_reset();
    s_if.s_data  = '0;
    s_if.s_valid = 1'b0;
    prog_reset   = 1'b0;
    tick(3);
    n_chk++;
    if ({ccff_head, ccff_clk_en, isol_n, busy, done, check_err, s_if.s_ready} !== 7'b0 ||
        bit_count !== '0) begin
      n_err++;
      $display("FAIL reset_state: head=%0b en=%0b isol_n=%0b busy=%0b done=%0b err=%0b ready=%0b cnt=%0d, required all 0",
               ccff_head, ccff_clk_en, isol_n, busy, done, check_err, s_if.s_ready, bit_count);
    end
    prog_reset = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_mid_load();
    int waited = 0;
    int base_en;
    s_if.s_data  = 8'h3C;
    s_if.s_valid = 1'b1;
    pulse_start();
    while (bit_count != CNT_W'(5) && waited < 100) begin
      tick(1);
      waited++;
    end
    n_chk++;
    if (bit_count !== CNT_W'(5)) begin
      n_err++;
      $display("FAIL mid_load_reach: bit_count=%0d, required 5", bit_count);
    end
    prog_reset = 1'b0;
    tick(1);
    n_chk++;
    if ({ccff_head, ccff_clk_en, isol_n, busy, done, check_err, s_if.s_ready} !== 7'b0 ||
        bit_count !== '0) begin
      n_err++;
      $display("FAIL mid_load_reset: head=%0b en=%0b isol_n=%0b busy=%0b done=%0b err=%0b ready=%0b cnt=%0d, required all 0",
               ccff_head, ccff_clk_en, isol_n, busy, done, check_err, s_if.s_ready, bit_count);
    end
    tick(1);
    prog_reset = 1'b1;
    base_en = got_q.size();
    tick(10);
    n_chk++;
    if (got_q.size() !== base_en || isol_n !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: enables=%0d isol_n=%0b busy=%0b, required 0 0 0",
               got_q.size() - base_en, isol_n, busy);
    end
    s_if.s_valid = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    run_load(CHAIN_LEN, 0, 1'b0, "basic");
  endtask

  task automatic test_stall();
    run_load(CHAIN_LEN, 10, 1'b0, "stall");
  endtask

  task automatic test_start_while_busy();
    run_load(CHAIN_LEN, 0, 1'b1, "start_busy");
  endtask

  task automatic test_chain_check();
    logic exp_err;
`ifdef CCFF_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    run_load(CHAIN_LEN - 1, 0, 1'b0, "short_chain");
    tick(5);
    n_chk++;
    if (check_err !== exp_err) begin
      n_err++;
      $display("FAIL check_err_sticky: got %0b, required %0b", check_err, exp_err);
    end
    run_load(CHAIN_LEN, 0, 1'b0, "good_chain");
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_basic();
    test_stall();
    test_start_while_busy();
    test_chain_check();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
